alu_exec_ctrl: RTL

Parametrised ALU control and execute stage for the MIPS datapath. It decodes `ALUOp_i`/`funct_i` into a 4-bit ALU control code, executes the operation on `DATA_W`-bit operands, and returns a registered result with a valid/ready handshake. Single-cycle ops complete in one cycle. An optional iterative multiplier (`mul`) takes `DATA_W` cycles and stalls the issuing stage through `ready_o`.

---
 rtl/alu_exec_ctrl_if.sv | 30 +++
 rtl/alu_exec_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Request/response bundle between the issuing stage and the ALU execute stage.
// The master side issues operations, and the slave side (the ALU) answers with
// registered results.
interface alu_exec_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               valid_i;
  logic               ready_o;
  logic [2:0]         ALUOp_i;
  logic [5:0]         funct_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [DATA_W-1:0]  src1_i;
  logic [DATA_W-1:0]  src2_i;
  logic               valid_o;
  logic [DATA_W-1:0]  result_o;
  logic               zero_o;
  logic               illegal_o;
  logic [3:0]         ALUCtrl_o;

  modport master (
    output valid_i, ALUOp_i, funct_i, shamt_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, zero_o, illegal_o, ALUCtrl_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i, shamt_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, zero_o, illegal_o, ALUCtrl_o
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU control decode and execute stage for the MIPS datapath.
// It decodes ALUOp/funct into a 4-bit control code and executes the operation.
// The result, zero and illegal flags come out one cycle after acceptance.
// Optional feature macro: ALU_MUL_EN builds an iterative radix-2 multiplier.
// That multiplier takes DATA_W cycles and holds ready_o low while it runs.
module alu_exec_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_exec_ctrl_if.slave bus
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SLLV = 4'b1010;
  localparam logic [3:0] C_SRLV = 4'b1011;
  localparam logic [3:0] C_MUL  = 4'b1100;
  localparam logic [3:0] C_ILL  = 4'b1111;

  logic [3:0]        code;
  logic              ill;
  logic [DATA_W-1:0] alu_res;
  logic              ready;
  logic              accept;
  logic              single;
  logic              mul_done;
  logic [DATA_W-1:0] mul_res;

  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              illegal_q;
  logic [3:0]        ctrl_q;

  // Decode the op class and the R-type function into the ALU control code
  always_comb begin
    code = C_ILL;
    ill  = 1'b1;
    case (bus.ALUOp_i)
      3'b000: begin code = C_ADD; ill = 1'b0; end
      3'b001: begin code = C_SUB; ill = 1'b0; end
      3'b010: begin code = C_OR;  ill = 1'b0; end
      3'b011: begin code = C_SLT; ill = 1'b0; end
      3'b100: begin code = C_AND; ill = 1'b0; end
      3'b111: begin
        case (bus.funct_i)
          6'b100000: begin code = C_ADD;  ill = 1'b0; end
          6'b100010: begin code = C_SUB;  ill = 1'b0; end
          6'b100100: begin code = C_AND;  ill = 1'b0; end
          6'b100101: begin code = C_OR;   ill = 1'b0; end
          6'b101010: begin code = C_SLT;  ill = 1'b0; end
          6'b000000: begin code = C_SLL;  ill = 1'b0; end
          6'b000010: begin code = C_SRL;  ill = 1'b0; end
          6'b000100: begin code = C_SLLV; ill = 1'b0; end
          6'b000110: begin code = C_SRLV; ill = 1'b0; end
`ifdef ALU_MUL_EN
          6'b011000: begin code = C_MUL;  ill = 1'b0; end
`endif
          default:   begin code = C_ILL;  ill = 1'b1; end
        endcase
      end
      default: begin code = C_ILL; ill = 1'b1; end
    endcase
  end

  // Single-cycle datapath; illegal and mul codes produce zero here
  always_comb begin
    alu_res = '0;
    case (code)
      C_ADD:  alu_res = bus.src1_i + bus.src2_i;
      C_SUB:  alu_res = bus.src1_i - bus.src2_i;
      C_AND:  alu_res = bus.src1_i & bus.src2_i;
      C_OR:   alu_res = bus.src1_i | bus.src2_i;
      C_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      C_SLL:  alu_res = bus.src2_i << bus.shamt_i;
      C_SRL:  alu_res = bus.src2_i >> bus.shamt_i;
      C_SLLV: alu_res = bus.src2_i << bus.src1_i[SHAMT_W-1:0];
      C_SRLV: alu_res = bus.src2_i >> bus.src1_i[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign accept = bus.valid_i && ready;

`ifdef ALU_MUL_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int         CNT_W = $clog2(DATA_W + 1);

  logic [0:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic              start_mul;

  assign ready     = (state_q == IDLE);
  assign start_mul = accept && (code == C_MUL);
  assign single    = accept && (code != C_MUL);
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  assign mul_res   = acc_d;

  // Multiplier FSM: latch operands on accept, then one shift-add step per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (state_q == IDLE) begin
      if (start_mul) begin
        mcand_q  <= bus.src1_i;
        mplier_q <= bus.src2_i;
        acc_q    <= '0;
        cnt_q    <= CNT_W'(DATA_W);
        state_q  <= BUSY;
      end
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_q <= IDLE;
      end
    end
  end
`else
  assign ready    = 1'b1;
  assign single   = accept;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  // Output registers: single-cycle results on accept, mul result when the last step lands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 4'b0000;
    end else begin
      valid_q <= single || mul_done;
      if (accept) begin
        ctrl_q <= code;
      end
      if (single) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= ill;
      end else if (mul_done) begin
        result_q  <= mul_res;
        zero_q    <= (mul_res == '0);
        illegal_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;
  assign bus.ALUCtrl_o = ctrl_q;

endmodule
